// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } ldr_state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs an incoming little-endian byte stream into one DATA_WIDTH word.
// full flags the push that completes the word.
module word_assembler
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  logic [BYTE_W-1:0]     byte_in,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  full
);

    localparam int BYTES = DATA_WIDTH / BYTE_W;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [CNT_W-1:0]              byte_cnt;
    logic [BYTES-1:0][BYTE_W-1:0]  lanes;

    assign full = push && (byte_cnt == CNT_W'(BYTES - 1));
    assign word = lanes;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt <= '0;
            lanes    <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
            lanes    <= '0;
        end else if (push) begin
            lanes[byte_cnt] <= byte_in;
            byte_cnt        <= byte_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader in front of the instruction memory: writes a byte stream as words
// from address 0, then hands the memory address port to the core PC.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len_in,
    input  logic                  byte_valid,
    input  logic [BYTE_W-1:0]     byte_in,
    output logic                  byte_ready,
    input  logic [ADDR_WIDTH-1:0] pc_addr,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  imem_we,
    output logic                  busy,
    output logic                  core_run
);

    localparam int              LEN_W   = ADDR_WIDTH + 1;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    ldr_state_t            state, state_nxt;
    logic [ADDR_WIDTH-1:0] word_ptr;
    logic [LEN_W-1:0]      len, len_clamped;
    logic                  start_ok, last_word, push, clear, word_full;
    logic [DATA_WIDTH-1:0] word;

    assign start_ok    = start && ((state == IDLE) || (state == DONE));
    assign len_clamped = (len_in > DEPTH_L) ? DEPTH_L : len_in;
    // Compare in LEN_W bits so a full-depth load ends at DEPTH-1 without wrapping.
    assign last_word   = ({1'b0, word_ptr} + LEN_W'(1)) == len;

    assign byte_ready = (state == LOAD);
    assign busy       = (state == LOAD) || (state == WRITE);
    assign core_run   = (state == DONE);
    assign push       = byte_valid && byte_ready;
    assign clear      = start_ok || (state == WRITE);

    word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .push    (push),
        .byte_in (byte_in),
        .word    (word),
        .full    (word_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_ptr <= '0;
            len      <= '0;
        end else if (start_ok) begin
            word_ptr <= '0;
            len      <= len_clamped;
        end else if ((state == WRITE) && !last_word) begin
            word_ptr <= word_ptr + 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        imem_we    = 1'b0;
        imem_wdata = '0;
        imem_addr  = word_ptr;
        case (state)
            IDLE: begin
                imem_addr = '0;
                if (start_ok) state_nxt = (len_clamped == '0) ? DONE : LOAD;
            end
            LOAD: begin
                if (word_full) state_nxt = WRITE;
            end
            WRITE: begin
                imem_we    = 1'b1;
                imem_wdata = word;
                state_nxt  = last_word ? DONE : LOAD;
            end
            DONE: begin
                imem_addr = pc_addr;
                if (start_ok) state_nxt = (len_clamped == '0) ? DONE : LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of load scenarios plus reset/DONE corner sequences.
module tb_imem_loader;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          reset, start, byte_valid;
    logic [AW:0]   len_in;
    logic [7:0]    byte_in;
    logic          byte_ready, imem_we, busy, core_run;
    logic [AW-1:0] pc_addr, imem_addr;
    logic [DW-1:0] imem_wdata;

    always #5 clk = ~clk;

    imem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len_in     (len_in),
        .byte_valid (byte_valid),
        .byte_in    (byte_in),
        .byte_ready (byte_ready),
        .pc_addr    (pc_addr),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_we    (imem_we),
        .busy       (busy),
        .core_run   (core_run)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0]    stream [0:2047];
    logic [AW-1:0] wq_addr [$];
    logic [DW-1:0] wq_data [$];

    typedef struct {
        int len;
        int nbytes;
        bit gap;
        int seed;
        int exp_writes;
        int exp_cyc;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Write logger plus per-cycle output invariants.
    always @(negedge clk) begin
        if (!reset) begin
            tests++;
            if (imem_we) begin
                wq_addr.push_back(imem_addr);
                wq_data.push_back(imem_wdata);
                if (byte_ready !== 1'b0 || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL write_cycle_ctrl: byte_ready=%b busy=%b, expected 0/1", byte_ready, busy);
                end
            end else if (imem_wdata !== '0) begin
                fails++;
                $display("FAIL wdata_idle: got 0x%0h, expected 0", imem_wdata);
            end
        end
    end

    task automatic run_load(input int len, input int nbytes, input bit gap,
                            output int cyc, output int nacc, output logic first_run);
        bit acc;
        int idx;
        idx = 0;
        cyc = 0;
        first_run = 1'bx;
        wq_addr.delete();
        wq_data.delete();
        @(posedge clk); #1;
        start = 1'b1;
        len_in = len[AW:0];
        byte_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            byte_valid = (idx < nbytes) && (!gap || (cyc % 2 == 0));
            byte_in = stream[idx];
            @(negedge clk);
            if (k == 0) first_run = core_run;
            if (core_run) break;
            acc = byte_valid && byte_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) idx++;
        end
        byte_valid = 1'b0;
        nacc = idx;
        chk("load_completes", {63'd0, core_run}, 64'd1);
    endtask

    task automatic check_writes(input string nm, input int nexp);
        int errs;
        logic [DW-1:0] ed;
        errs = 0;
        chk($sformatf("%s_count", nm), wq_data.size(), nexp);
        for (int k = 0; k < nexp && k < wq_data.size(); k++) begin
            ed = {stream[4*k+3], stream[4*k+2], stream[4*k+1], stream[4*k]};
            if (wq_addr[k] !== k[AW-1:0] || wq_data[k] !== ed) begin
                if (errs < 4)
                    $display("  write %0d: addr 0x%0h data 0x%0h, model addr 0x%0h data 0x%0h",
                             k, wq_addr[k], wq_data[k], k[AW-1:0], ed);
                errs++;
            end
        end
        chk($sformatf("%s_content_errs", nm), errs, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, nacc;
        logic fr;

        reset = 1'b1; start = 1'b0; len_in = '0; byte_valid = 1'b0; byte_in = '0; pc_addr = 8'h5A;
        for (int i = 0; i < 2048; i++) stream[i] = 8'h00;

        // Reset state
        @(negedge clk);
        chk("rst_byte_ready", byte_ready, 0);
        chk("rst_we",         imem_we, 0);
        chk("rst_wdata",      imem_wdata, 0);
        chk("rst_addr",       imem_addr, 0);
        chk("rst_busy",       busy, 0);
        chk("rst_core_run",   core_run, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", byte_ready, 0);
        chk("post_rst_run",   core_run, 0);
        chk("idle_addr",      imem_addr, 0);

        // Two-instruction program, back-to-back bytes
        {stream[0], stream[1], stream[2], stream[3]} = {8'h13, 8'h00, 8'h00, 8'h00};
        {stream[4], stream[5], stream[6], stream[7]} = {8'h93, 8'h00, 8'h10, 8'h00};
        run_load(2, 8, 1'b0, cyc, nacc, fr);
        chk("prog_cycles", cyc, 10);
        chk("prog_nwrites", wq_data.size(), 2);
        if (wq_data.size() == 2) begin
            chk("prog_addr0", wq_addr[0], 8'h00);
            chk("prog_data0", wq_data[0], 32'h0000_0013);
            chk("prog_addr1", wq_addr[1], 8'h01);
            chk("prog_data1", wq_data[1], 32'h0010_0093);
        end

        // Scenario table: len, bytes offered, gapped valid, seed, writes, start->core_run cycles
        vecs[0] = '{len: 2,   nbytes: 8,    gap: 1'b0, seed: 1, exp_writes: 2,   exp_cyc: 10};
        vecs[1] = '{len: 2,   nbytes: 8,    gap: 1'b1, seed: 2, exp_writes: 2,   exp_cyc: 16};
        vecs[2] = '{len: 0,   nbytes: 4,    gap: 1'b0, seed: 3, exp_writes: 0,   exp_cyc: 0};
        vecs[3] = '{len: 1,   nbytes: 4,    gap: 1'b0, seed: 4, exp_writes: 1,   exp_cyc: 5};
        vecs[4] = '{len: 3,   nbytes: 14,   gap: 1'b0, seed: 5, exp_writes: 3,   exp_cyc: 15};
        vecs[5] = '{len: 300, nbytes: 1032, gap: 1'b0, seed: 6, exp_writes: 256, exp_cyc: 1280};

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 2048; i++) stream[i] = 8'(i * 37 + vecs[v].seed * 11 + 1);
            run_load(vecs[v].len, vecs[v].nbytes, vecs[v].gap, cyc, nacc, fr);
            chk($sformatf("v%0d_cycles", v), cyc, vecs[v].exp_cyc);
            chk($sformatf("v%0d_accepted", v), nacc, vecs[v].exp_writes * 4);
            chk($sformatf("v%0d_run_after_start", v), fr, (vecs[v].len == 0) ? 1 : 0);
            check_writes($sformatf("v%0d", v), vecs[v].exp_writes);
            if (vecs[v].exp_writes == 256 && wq_addr.size() == 256)
                chk("clamp_last_addr", wq_addr[255], 8'hFF);
        end

        // DONE: PC pass-through
        pc_addr = 8'h05; #1;
        chk("done_addr_pc",  imem_addr, 8'h05);
        chk("done_we",       imem_we, 0);
        chk("done_ready",    byte_ready, 0);
        chk("done_run",      core_run, 1);
        pc_addr = 8'hC3; #1;
        chk("done_addr_pc2", imem_addr, 8'hC3);

        // Reload from DONE
        {stream[0], stream[1], stream[2], stream[3]} = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
        run_load(1, 4, 1'b0, cyc, nacc, fr);
        chk("reload_run_drops", fr, 0);
        chk("reload_nwrites", wq_data.size(), 1);
        if (wq_data.size() == 1) begin
            chk("reload_addr", wq_addr[0], 8'h00);
            chk("reload_data", wq_data[0], 32'hD4C3_B2A1);
        end

        // Reset mid-word: two bytes in, then asynchronous reset
        wq_addr.delete();
        wq_data.delete();
        @(posedge clk); #1 start = 1'b1; len_in = 9'd1;
        @(posedge clk); #1 start = 1'b0; byte_valid = 1'b1; byte_in = 8'hEE;
        @(posedge clk); #1 byte_in = 8'hDD;
        @(posedge clk); #1 byte_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy",  busy, 0);
        chk("midrst_ready", byte_ready, 0);
        chk("midrst_we",    imem_we, 0);
        chk("midrst_addr",  imem_addr, 0);
        chk("midrst_run",   core_run, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_ready_after", byte_ready, 0);
        chk("midrst_run_after",   core_run, 0);
        chk("midrst_no_write",    wq_data.size(), 0);

        {stream[0], stream[1], stream[2], stream[3]} = {8'h01, 8'h02, 8'h03, 8'h04};
        run_load(1, 4, 1'b0, cyc, nacc, fr);
        chk("after_rst_cycles", cyc, 5);
        chk("after_rst_nwrites", wq_data.size(), 1);
        if (wq_data.size() == 1) begin
            chk("after_rst_addr", wq_addr[0], 8'h00);
            chk("after_rst_data", wq_data[0], 32'h0403_0201);
        end

        // Reset while in DONE drops core_run without waiting for a clock
        #2 reset = 1'b1;
        #1;
        chk("done_rst_run",  core_run, 0);
        chk("done_rst_addr", imem_addr, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("done_rst_run_after", core_run, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
